multi_ported_banked_memory: RTL and testbench
=============================================

// Module: multi_ported_banked_memory
// PURPOSE
// - Parametrised successor of the fixed 3-port memory: NUM_PORTS request ports share 2**BANK_BITS single-ported banks.
// - Registers requests, arbitrates per bank with a rotating priority and serialises bank conflicts.
// - Holds callers via freeze_inputs; returns read data and write acks on the originating port.
// - Sits between port-side requesters (CPU/DMA lanes) and on-chip SRAM storage.
// PARAMETERS
// - NUM_PORTS  3   number of request ports, 2..8
// - ADDR_W     12  word address width
// - DATA_W     16  data width
// - BANK_BITS  2   bank select = addr[BANK_BITS-1:0]; row = addr[ADDR_W-1:BANK_BITS]; 1 <= BANK_BITS < ADDR_W
// PORTS
// - clk             in   1                 clock, all state on rising edge
// - reset           in   1                 asynchronous, active-high reset
// - halt            in   1                 stall: no bank access, priority pointer frozen
// - port_addr       in   NUM_PORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
// - port_data_in    in   NUM_PORTS*DATA_W  write data, port i at [i*DATA_W +: DATA_W]
// - port_wen        in   NUM_PORTS         1 = write, 0 = read
// - port_valid_in   in   NUM_PORTS         request valid
// - port_data_out   out  NUM_PORTS*DATA_W  read data, or echoed write data
// - port_valid_out  out  NUM_PORTS         one-cycle completion pulse per request
// - freeze_inputs   out  1                 1 = inputs not captured this edge; hold them stable
// - conflict_count  out  16                only when MPBM_CONFLICT_STATS_EN is defined
// BEHAVIOUR
// - Reset: all request regs, pending[], prio_ptr, port_data_out, port_valid_out and freeze_inputs are 0.
// - Memory contents are not reset.
// - Reset mid-operation drops all pending requests; no valid_out is produced for them.
// - Capture: on an edge with freeze_inputs=0, every port's addr/data/wen/valid is registered.
//   - pending[i] is set to port_valid_in[i].
//   - With freeze_inputs=1, request regs hold.
// - Arbitration is combinational from registered state, per bank.
//   - Among pending ports that target the bank, search priority order prio_ptr, prio_ptr+1, ... (mod NUM_PORTS).
//   - The first port found is granted.
//   - At most one grant per bank per cycle; ports on different banks are granted in the same cycle.
// - Access at the edge after a grant:
//   - Write stores data_in at [bank][row].
//   - Read fetches [bank][row].
//   - The granted pending bit clears.
// - Response:
//   - port_valid_out[i]=1 for exactly the cycle after the grant edge.
//   - port_data_out slice = read data, or the written data for a write.
//   - A non-granted slice holds its previous value; its valid_out is 0.
// - Latency, no conflict: inputs captured at edge E0, granted in cycle E0..E1, valid_out high after E1 (2 edges).
//   - Each extra conflict loser adds 1 cycle.
// - freeze_inputs = halt | (|(pending & ~grant)).
//   - Low in any cycle where every pending request is granted.
//   - This allows back-to-back capture at full rate.
// - prio_ptr advances by 1 (wraps NUM_PORTS-1 -> 0) on every non-halted cycle with >=1 grant; otherwise it holds.
// - Intra-cycle ordering, same address on different ports: same bank, so the requests serialise in priority order.
//   - A read issued after a write observes the new data.
//   - There is no same-cycle read/write hazard.
// - halt=1:
//   - grant=0, valid_out=0, data_out held, pending held, freeze_inputs=1.
//   - When released, resume exactly where stopped.
// CONFIGURATION
// - MPBM_CONFLICT_STATS_EN defined:
//   - conflict_count output exists, reset 0.
//   - +1 per non-halted cycle where some pending port is not granted.
//   - Saturates at 16'hFFFF.
// - Undefined: port and counter absent; all other behaviour identical.
// TESTING (defaults NUM_PORTS=3, ADDR_W=12, DATA_W=16, BANK_BITS=2)
// - Write, then read back: port0 write 0x004/0xBEEF, then port1 read 0x004.
//   - p0 valid_out at edge+2 with data 0xBEEF.
//   - p1 valid_out 2 edges after its capture with data 0xBEEF.
// - No conflict: after reset, reads on 0x000/0x001/0x002 from ports 0/1/2.
//   - All three valid_out pulse in the same cycle.
//   - freeze_inputs stays 0.
// - Bank conflict: right after reset (prio_ptr=0), ports 0/1/2 read 0x000/0x004/0x008.
//   - freeze_inputs=1 for 2 cycles.
//   - valid_out pulses p0, p1, p2 on consecutive cycles.
// - Rotation: set prio_ptr=1 by one prior granted cycle, then repeat the all-bank-0 conflict.
//   - Completion order is p1, p2, p0.
// - Halt and reset mid-conflict:
//   - halt=1 for 3 cycles after the first grant: no valid_out, freeze=1; remaining two complete after release.
//   - reset pulse mid-conflict: all outputs 0 next cycle, no further valid_out.
// - Stats (MPBM_CONFLICT_STATS_EN): the all-bank-0 3-port conflict gives conflict_count=2.
//   - Counter held at 16'hFFFF does not wrap.

Source files
------------

// File: rtl/multi_ported_banked_memory.sv
// NUM_PORTS request ports sharing 2**BANK_BITS single-ported banks with rotating per-bank priority.
// Optional feature macro: MPBM_CONFLICT_STATS_EN adds a saturating conflict_count output.
module multi_ported_banked_memory #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int BANK_BITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          halt,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_data_in,
  input  logic [NUM_PORTS-1:0]          port_wen,
  input  logic [NUM_PORTS-1:0]          port_valid_in,
  output logic [NUM_PORTS*DATA_W-1:0]   port_data_out,
  output logic [NUM_PORTS-1:0]          port_valid_out,
  output logic                          freeze_inputs
`ifdef MPBM_CONFLICT_STATS_EN
  ,
  output logic [15:0]                   conflict_count
`endif
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int ROW_W     = ADDR_W - BANK_BITS;
  localparam int ROWS      = 2 ** ROW_W;
  localparam int PW        = $clog2(NUM_PORTS);

  typedef logic [PW:0] rank_t;

  logic [ADDR_W-1:0]    req_addr [NUM_PORTS];
  logic [DATA_W-1:0]    req_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_wen;
  logic [NUM_PORTS-1:0] pending;
  logic [PW-1:0]        prio_ptr;

  logic [BANK_BITS-1:0] bank_sel [NUM_PORTS];
  logic [ROW_W-1:0]     row_sel  [NUM_PORTS];
  rank_t                rank     [NUM_PORTS];
  logic [NUM_PORTS-1:0] blocked;
  logic [NUM_PORTS-1:0] grant;

  logic [DATA_W-1:0]    mem [NUM_BANKS][ROWS];

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      bank_sel[j] = req_addr[j][BANK_BITS-1:0];
      row_sel[j]  = req_addr[j][ADDR_W-1:BANK_BITS];
    end
  end

  // Distance of each port from the priority pointer, modulo NUM_PORTS; lower wins.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (rank_t'(j) >= {1'b0, prio_ptr})
        rank[j] = rank_t'(j) - {1'b0, prio_ptr};
      else
        rank[j] = rank_t'(j) + rank_t'(NUM_PORTS) - {1'b0, prio_ptr};
    end
  end

  always_comb begin
    blocked = '0;
    grant   = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (k != j && pending[k] && bank_sel[k] == bank_sel[j] && rank[k] < rank[j])
          blocked[j] = 1'b1;
      end
      grant[j] = !halt && pending[j] && !blocked[j];
    end
  end

  assign freeze_inputs = halt | (|(pending & ~grant));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        req_addr[j] <= '0;
        req_data[j] <= '0;
      end
      req_wen        <= '0;
      pending        <= '0;
      prio_ptr       <= '0;
      port_data_out  <= '0;
      port_valid_out <= '0;
    end else begin
      // Captured requests replace granted ones; only possible when nothing is left waiting.
      if (!freeze_inputs) begin
        for (int j = 0; j < NUM_PORTS; j++) begin
          req_addr[j] <= port_addr[j*ADDR_W +: ADDR_W];
          req_data[j] <= port_data_in[j*DATA_W +: DATA_W];
          req_wen[j]  <= port_wen[j];
          pending[j]  <= port_valid_in[j];
        end
      end else begin
        pending <= pending & ~grant;
      end

      port_valid_out <= grant;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (grant[j])
          port_data_out[j*DATA_W +: DATA_W] <= req_wen[j] ? req_data[j]
                                                          : mem[bank_sel[j]][row_sel[j]];
      end

      if (!halt && (|grant)) begin
        if (prio_ptr == PW'(NUM_PORTS - 1))
          prio_ptr <= '0;
        else
          prio_ptr <= prio_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; at most one granted port per bank, so writes never collide.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (grant[j] && req_wen[j])
        mem[bank_sel[j]][row_sel[j]] <= req_data[j];
    end
  end

`ifdef MPBM_CONFLICT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_count <= '0;
    else if (!halt && (|(pending & ~grant)) && conflict_count != 16'hFFFF)
      conflict_count <= conflict_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multi_ported_banked_memory.sv
// Directed bench for multi_ported_banked_memory at default parameters (3 ports, 4 banks).
// Also checks conflict_count when MPBM_CONFLICT_STATS_EN is defined.
module tb_multi_ported_banked_memory;

  localparam int NP = 3;
  localparam int AW = 12;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              halt;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*DW-1:0]  port_data_in;
  logic [NP-1:0]     port_wen;
  logic [NP-1:0]     port_valid_in;
  logic [NP*DW-1:0]  port_data_out;
  logic [NP-1:0]     port_valid_out;
  logic              freeze_inputs;
`ifdef MPBM_CONFLICT_STATS_EN
  logic [15:0]       conflict_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [NP-1:0] seen;

  multi_ported_banked_memory #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BANK_BITS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
    .port_addr      (port_addr),
    .port_data_in   (port_data_in),
    .port_wen       (port_wen),
    .port_valid_in  (port_valid_in),
    .port_data_out  (port_data_out),
    .port_valid_out (port_valid_out),
    .freeze_inputs  (freeze_inputs)
`ifdef MPBM_CONFLICT_STATS_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic wen, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    port_valid_in[p]         = 1'b1;
    port_wen[p]              = wen;
    port_addr[p*AW +: AW]    = addr;
    port_data_in[p*DW +: DW] = data;
  endtask

  task automatic clear_ports();
    port_valid_in = '0;
    port_wen      = '0;
    port_addr     = '0;
    port_data_in  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] dout(input int p);
    return port_data_out[p*DW +: DW];
  endfunction

  task automatic start_conflict();
    set_port(0, 1'b0, 12'h000, 16'h0);
    set_port(1, 1'b0, 12'h004, 16'h0);
    set_port(2, 1'b0, 12'h008, 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    halt  = 1'b0;
    clear_ports();
    tick();
    tick();
    chk("rst_valid", port_valid_out, 0);
    chk("rst_data", port_data_out[31:0], 0);
    chk("rst_freeze", freeze_inputs, 0);
    reset = 1'b0;

    // write 0x004 on p0, then read it back on p1
    set_port(0, 1'b1, 12'h004, 16'hBEEF);
    tick();
    clear_ports();
    set_port(1, 1'b0, 12'h004, 16'h0);
    chk("wr_freeze", freeze_inputs, 0);
    tick();
    clear_ports();
    chk("wr_valid", port_valid_out, 3'b001);
    chk("wr_echo", dout(0), 16'hBEEF);
    tick();
    chk("rd_valid", port_valid_out, 3'b010);
    chk("rd_data", dout(1), 16'hBEEF);

    // no conflict: three different banks
    do_reset();
    set_port(0, 1'b0, 12'h000, 16'h0);
    set_port(1, 1'b0, 12'h001, 16'h0);
    set_port(2, 1'b0, 12'h002, 16'h0);
    tick();
    clear_ports();
    chk("nc_freeze0", freeze_inputs, 0);
    tick();
    chk("nc_valid", port_valid_out, 3'b111);
    chk("nc_freeze1", freeze_inputs, 0);

    // all-bank-0 conflict from prio_ptr=0
    do_reset();
    start_conflict();
    tick();
    clear_ports();
    chk("cf_freeze0", freeze_inputs, 1);
    tick();
    chk("cf_v0", port_valid_out, 3'b001);
    chk("cf_freeze1", freeze_inputs, 1);
    tick();
    chk("cf_v1", port_valid_out, 3'b010);
    chk("cf_d1", dout(1), 16'hBEEF);
    chk("cf_freeze2", freeze_inputs, 0);
    tick();
    chk("cf_v2", port_valid_out, 3'b100);
`ifdef MPBM_CONFLICT_STATS_EN
    chk("cf_count", conflict_count, 2);
`endif

    // rotation: one granted cycle moves prio_ptr to 1
    do_reset();
    set_port(0, 1'b0, 12'h001, 16'h0);
    tick();
    clear_ports();
    tick();
    chk("rot_pre", port_valid_out, 3'b001);
    start_conflict();
    tick();
    clear_ports();
    tick();
    chk("rot_v1", port_valid_out, 3'b010);
    tick();
    chk("rot_v2", port_valid_out, 3'b100);
    tick();
    chk("rot_v0", port_valid_out, 3'b001);

    // halt for 3 cycles after the first grant
    do_reset();
    set_port(0, 1'b1, 12'h000, 16'h1234);
    set_port(1, 1'b0, 12'h004, 16'h0);
    set_port(2, 1'b0, 12'h008, 16'h0);
    tick();
    clear_ports();
    tick();
    chk("h_v0", port_valid_out, 3'b001);
    chk("h_d0", dout(0), 16'h1234);
    halt = 1'b1;
    #1;
    chk("h_freeze", freeze_inputs, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("h_valid", port_valid_out, 0);
      chk("h_hold", dout(0), 16'h1234);
    end
    halt = 1'b0;
    tick();
    chk("h_v1", port_valid_out, 3'b010);
    chk("h_d1", dout(1), 16'hBEEF);
    tick();
    chk("h_v2", port_valid_out, 3'b100);

    // reset pulse mid-conflict
    do_reset();
    start_conflict();
    tick();
    clear_ports();
    tick();
    chk("r_v0", port_valid_out, 3'b001);
    reset = 1'b1;
    tick();
    chk("r_valid", port_valid_out, 0);
    chk("r_data", port_data_out[31:0], 0);
    chk("r_freeze", freeze_inputs, 0);
    reset = 1'b0;
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen = seen | port_valid_out;
    end
    chk("r_none", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
